// File: rtl/note_row_decoder.sv
// Scan-line to note-lane decoder: tracks the raster with incremental counters
// and reports the lane, in-lane offset and staff-line flag of the current line.
module note_row_decoder #(
    parameter int unsigned TOP_Y     = 40,
    parameter int unsigned ROW_PITCH = 40,
    parameter int unsigned NUM_NOTES = 10,
    parameter int unsigned LINE_W    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       line_start,
    output logic [9:0] y_cur,
    output logic [3:0] note,
    output logic       in_staff,
    output logic       staff_line,
    output logic [5:0] row_off
);

    typedef enum logic [1:0] {
        ABOVE   = 2'd0,
        IN_ROWS = 2'd1,
        BELOW   = 2'd2
    } state_t;

    localparam logic [10:0] TOP_Y11     = 11'(TOP_Y);
    localparam logic [6:0]  PITCH7      = 7'(ROW_PITCH);
    localparam logic [6:0]  LINE_W7     = 7'(LINE_W);
    localparam logic [3:0]  LAST_NOTE   = 4'(NUM_NOTES - 1);
    localparam logic        TOP_IS_ZERO = (TOP_Y == 0);

    state_t     state, state_n;
    logic [9:0] y_n;
    logic [3:0] note_n;
    logic [5:0] row_n;
    logic       in_staff_n;
    logic       staff_line_n;

    // Line counter holds at the last representable line instead of wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic row_wraps(input logic [5:0] r);
        return ({1'b0, r} + 7'd1) == PITCH7;
    endfunction

    always_comb begin
        state_n = state;
        y_n     = y_cur;
        note_n  = note;
        row_n   = row_off;
        if (frame_start) begin
            y_n   = 10'd0;
            row_n = 6'd0;
            if (TOP_IS_ZERO) begin
                state_n = IN_ROWS;
                note_n  = 4'd0;
            end else begin
                state_n = ABOVE;
                note_n  = 4'hF;
            end
        end else if (line_start) begin
            y_n = sat_inc(y_cur);
            case (state)
                ABOVE: begin
                    if (({1'b0, y_cur} + 11'd1) == TOP_Y11) begin
                        state_n = IN_ROWS;
                        note_n  = 4'd0;
                        row_n   = 6'd0;
                    end
                end
                IN_ROWS: begin
                    if (row_wraps(row_off)) begin
                        row_n = 6'd0;
                        if (note == LAST_NOTE) begin
                            state_n = BELOW;
                            note_n  = 4'hF;
                        end else begin
                            note_n = note + 4'd1;
                        end
                    end else begin
                        row_n = row_off + 6'd1;
                    end
                end
                default: begin
                    state_n = BELOW;
                end
            endcase
        end
        in_staff_n   = (state_n == IN_ROWS);
        staff_line_n = in_staff_n && ({1'b0, row_n} < LINE_W7);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ABOVE;
            y_cur      <= 10'd0;
            note       <= 4'hF;
            row_off    <= 6'd0;
            in_staff   <= 1'b0;
            staff_line <= 1'b0;
        end else begin
            state      <= state_n;
            y_cur      <= y_n;
            note       <= note_n;
            row_off    <= row_n;
            in_staff   <= in_staff_n;
            staff_line <= staff_line_n;
        end
    end

endmodule
